cpu_loader: RTL and testbench
=============================

Name: cpu_loader

Overview:
- Byte-stream program loader directly upstream of the pipelined CPU core.
- Drives the core's debug memory-write ports (inst_we/inst_addr/inst_in, data_we/data_addr/data_in).
- Holds the core in reset while images are written into instruction and data memory, then releases it on command.
- Byte source is a UART receiver or testbench, using a valid/ready handshake.

Parameters:
- ADDR_W, 8, word-address width of both memories; addresses wrap modulo 2^ADDR_W.
- HDR_INST, 8'h49, header byte selecting instruction-memory load ('I').
- HDR_DATA, 8'h44, header byte selecting data-memory load ('D').
- HDR_GO, 8'h47, header byte releasing the CPU ('G').
- HDR_HALT, 8'h48, header byte re-asserting CPU reset ('H').

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid; a byte transfers when rx_valid && rx_ready at a rising edge.
- rx_ready  out  1  loader can accept a byte.
- inst_we  out  1  one-cycle write strobe to instruction memory.
- data_we  out  1  one-cycle write strobe to data memory.
- inst_addr  out  ADDR_W  instruction-memory word address.
- data_addr  out  ADDR_W  data-memory word address.
- wdata  out  32  assembled word; drives both inst_in and data_in.
- cpu_rstn  out  1  active-low reset to the CPU core.
- busy  out  1  a load transaction is in progress.
- err  out  1  sticky protocol error flag.

Behaviour:
- Reset (rstn low, async): state=IDLE; inst_we=0, data_we=0; inst_addr=0, data_addr=0; wdata=0; cpu_rstn=0; busy=0; err=0. Byte counter and word counter are cleared. Reset mid-load abandons the transfer; words already written stay in memory.
- rx_ready: high in IDLE, ADDR, CNT, PAYLOAD and RUN. Low for exactly the one cycle a write strobe is high, i.e. at most one strobe per 5 cycles.
- IDLE:
  - HDR_INST or HDR_DATA: latch target, busy=1, go to ADDR.
  - HDR_GO: if err=0, cpu_rstn=1 on the next edge and go to RUN; if err=1, ignored.
  - HDR_HALT: ignored.
  - Any other byte: err=1, stay in IDLE.
- ADDR: byte is the start word address; load it into the target address register, go to CNT.
- CNT: byte N is the word count; N=0 means 256 words (2^ADDR_W for ADDR_W=8). Go to PAYLOAD.
- PAYLOAD:
  - Bytes arrive little-endian; byte k of a word goes to wdata[8k+7:8k].
  - The cycle after the 4th byte is accepted: the target's strobe is high for 1 cycle with the current address and the complete wdata.
  - The following edge increments the target address (wrapping 8'hFF to 8'h00) and decrements the word count.
  - When the count reaches 0 after the strobe: busy=0, go to IDLE. With LOADER_CHECKSUM_EN defined, go to CSUM instead.
- Write latency: 1 cycle from acceptance of the 4th byte to the strobe. The non-target address register is unchanged.
- While busy=1 or in IDLE before GO, cpu_rstn=0.
- RUN:
  - HDR_HALT: cpu_rstn=0 on the next edge, go to IDLE.
  - HDR_INST or HDR_DATA: cpu_rstn=0 on the same edge the header is accepted, then proceed as from IDLE (hot reload).
  - All other bytes are ignored; err is not set in RUN.
- err clears only on rstn.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last payload word, state CSUM accepts one byte.
  - It is compared with the XOR of all payload bytes of this transaction; the running XOR clears on header acceptance.
  - On mismatch err=1. Either way busy=0 and go to IDLE.
  - Because GO is refused while err=1, a bad image never runs.
- Not defined: no CSUM state, no checksum logic; the transaction ends after the last word.

Test Plan:
- 'I', 0x10, 0x02, bytes 13 05 10 00 93 05 20 00 -> inst_we pulses twice: addr 0x10 wdata 0x00100513, addr 0x11 wdata 0x00200593. data_we never high, busy falls after the 2nd strobe, cpu_rstn stays 0.
- 'D', 0xFF, 0x02, 8 payload bytes -> data_we at addr 0xFF then 0x00 (wrap). inst_addr unchanged.
- Idle byte 0x55, then 'G' -> err=1 and cpu_rstn stays 0. After rstn pulse, 'G' -> cpu_rstn=1 one cycle after acceptance.
- 'G', then 'I', 0x00, 0x01, 4 bytes -> cpu_rstn drops on the edge accepting 'I', one inst_we strobe, cpu_rstn stays 0 until the next 'G'.
- rx_valid held high continuously through a 1-word load -> rx_ready low exactly during the strobe cycle; no byte lost or duplicated. Assert rstn low after the 2nd payload byte -> all outputs at reset values immediately; no strobe issued.
- With LOADER_CHECKSUM_EN: 'D', 0x00, 0x01, 01 02 03 04, checksum 0x04 -> err=0. Same with checksum 0x05 -> err=1 and the following 'G' is ignored.

Source files
------------

// File: rtl/cpu_loader.sv
// Byte-stream program loader: writes instruction/data memory images through the
// core's debug write ports and gates the core reset. Optional checksum: LOADER_CHECKSUM_EN.
module cpu_loader #(
  parameter int         ADDR_W   = 8,
  parameter logic [7:0] HDR_INST = 8'h49,
  parameter logic [7:0] HDR_DATA = 8'h44,
  parameter logic [7:0] HDR_GO   = 8'h47,
  parameter logic [7:0] HDR_HALT = 8'h48
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              inst_we,
  output logic              data_we,
  output logic [ADDR_W-1:0] inst_addr,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       wdata,
  output logic              cpu_rstn,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CNT,
    S_PAYLOAD,
    S_WRITE,
    S_RUN
`ifdef LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_tgt_data;
  logic [ADDR_W-1:0] r_inst_addr;
  logic [ADDR_W-1:0] r_data_addr;
  logic [8:0]        r_words;
  logic [1:0]        r_byte_idx;
  logic              r_cpu_rstn;
  logic              r_err;

  logic              w_accept;
  logic              w_is_load_hdr;
  logic              w_last_word;
  logic              w_hdr_take;
  logic              w_go;
  logic              w_halt;
  logic              w_bad_byte;
  logic              w_csum_bad;
  logic              w_payload_take;
  logic [ADDR_W-1:0] w_rx_addr;
  logic [31:0]       w_wdata;

  assign w_accept       = rx_valid && rx_ready;
  assign w_is_load_hdr  = (rx_data == HDR_INST) || (rx_data == HDR_DATA);
  assign w_last_word    = (r_words == 9'd1);
  assign w_payload_take = (r_state == S_PAYLOAD) && w_accept;
  assign w_rx_addr      = ADDR_W'(rx_data);

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_csum;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_csum <= 8'h00;
    end else if (w_hdr_take) begin
      r_csum <= 8'h00;
    end else if (w_payload_take) begin
      r_csum <= r_csum ^ rx_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_hdr_take   = 1'b0;
    w_go         = 1'b0;
    w_halt       = 1'b0;
    w_bad_byte   = 1'b0;
    w_csum_bad   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_load_hdr) begin
            w_hdr_take   = 1'b1;
            w_state_next = S_ADDR;
          end else if (rx_data == HDR_GO) begin
            // A flagged error locks the core in reset until rstn.
            if (!r_err) begin
              w_go         = 1'b1;
              w_state_next = S_RUN;
            end
          end else if (rx_data != HDR_HALT) begin
            w_bad_byte = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (w_accept) w_state_next = S_CNT;
      end
      S_CNT: begin
        if (w_accept) w_state_next = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (w_accept && (r_byte_idx == 2'd3)) w_state_next = S_WRITE;
      end
      S_WRITE: begin
        if (w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
          w_state_next = S_CSUM;
`else
          w_state_next = S_IDLE;
`endif
        end else begin
          w_state_next = S_PAYLOAD;
        end
      end
      S_RUN: begin
        if (w_accept) begin
          if (w_is_load_hdr) begin
            w_hdr_take   = 1'b1;
            w_state_next = S_ADDR;
          end else if (rx_data == HDR_HALT) begin
            w_halt       = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (w_accept) begin
          w_csum_bad   = (rx_data != r_csum);
          w_state_next = S_IDLE;
        end
      end
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tgt_data  <= 1'b0;
      r_inst_addr <= '0;
      r_data_addr <= '0;
      r_words     <= 9'd0;
      r_byte_idx  <= 2'd0;
      r_cpu_rstn  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_hdr_take) begin
        r_tgt_data <= (rx_data == HDR_DATA);
        r_byte_idx <= 2'd0;
      end
      if ((r_state == S_ADDR) && w_accept) begin
        if (r_tgt_data) r_data_addr <= w_rx_addr;
        else            r_inst_addr <= w_rx_addr;
      end
      // A count byte of zero stands for a full 256-word image.
      if ((r_state == S_CNT) && w_accept) begin
        r_words <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
      end
      if (w_payload_take) begin
        r_byte_idx <= r_byte_idx + 2'd1;
      end
      if (r_state == S_WRITE) begin
        if (r_tgt_data) r_data_addr <= r_data_addr + 1'b1;
        else            r_inst_addr <= r_inst_addr + 1'b1;
        r_words <= r_words - 9'd1;
      end
      if (w_go) begin
        r_cpu_rstn <= 1'b1;
      end else if (w_hdr_take || w_halt) begin
        r_cpu_rstn <= 1'b0;
      end
      if (w_bad_byte || w_csum_bad) begin
        r_err <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] r_byte;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_byte <= 8'h00;
      end else if (w_payload_take && (r_byte_idx == 2'(gi))) begin
        r_byte <= rx_data;
      end
    end

    assign w_wdata[8*gi +: 8] = r_byte;
  end

  assign rx_ready  = (r_state != S_WRITE);
  assign inst_we   = (r_state == S_WRITE) && !r_tgt_data;
  assign data_we   = (r_state == S_WRITE) &&  r_tgt_data;
  assign inst_addr = r_inst_addr;
  assign data_addr = r_data_addr;
  assign wdata     = w_wdata;
  assign cpu_rstn  = r_cpu_rstn;
  assign err       = r_err;
  assign busy      = (r_state != S_IDLE) && (r_state != S_RUN);

endmodule

// File: tb/tb_cpu_loader.sv
// Randomized self-checking bench for cpu_loader: transaction-level model of
// expected memory writes, address pointers, err and cpu_rstn.
module tb_cpu_loader;

  localparam logic [7:0] H_I    = 8'h49;
  localparam logic [7:0] H_D    = 8'h44;
  localparam logic [7:0] H_GO   = 8'h47;
  localparam logic [7:0] H_HALT = 8'h48;

  typedef struct packed {
    logic        is_data;
    logic [7:0]  addr;
    logic [31:0] word;
  } wr_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        inst_we;
  logic        data_we;
  logic [7:0]  inst_addr;
  logic [7:0]  data_addr;
  logic [31:0] wdata;
  logic        cpu_rstn;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  wr_t        got_q[$];
  logic [7:0] payload_q[$];

  bit         m_err = 1'b0;
  bit         m_run = 1'b0;
  logic [7:0] m_inst_addr = 8'h00;
  logic [7:0] m_data_addr = 8'h00;

  cpu_loader #(.ADDR_W(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .inst_we   (inst_we),
    .data_we   (data_we),
    .inst_addr (inst_addr),
    .data_addr (data_addr),
    .wdata     (wdata),
    .cpu_rstn  (cpu_rstn),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Strobe monitor: records every write and checks the cycle-level rules around it.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (inst_we || data_we) begin
        got_q.push_back('{is_data: data_we, addr: (data_we ? data_addr : inst_addr), word: wdata});
        check_eq("strobe_cpu_rstn", 32'(cpu_rstn), 32'(0));
        check_eq("strobe_busy", 32'(busy), 32'(1));
      end
      check_eq("dual_strobe", 32'(inst_we & data_we), 32'(0));
      check_eq("ready_vs_strobe", 32'(rx_ready), 32'(!(inst_we || data_we)));
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit keep);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("rx_ready_timeout", 32'(n >= 50), 32'(0));
    @(posedge clk); #1;
    if (!keep) rx_valid = 1'b0;
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_state();
    check_eq("rst_inst_we", 32'(inst_we), 32'(0));
    check_eq("rst_data_we", 32'(data_we), 32'(0));
    check_eq("rst_inst_addr", 32'(inst_addr), 32'(0));
    check_eq("rst_data_addr", 32'(data_addr), 32'(0));
    check_eq("rst_wdata", wdata, 32'(0));
    check_eq("rst_cpu_rstn", 32'(cpu_rstn), 32'(0));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_err", 32'(err), 32'(0));
    check_eq("rst_rx_ready", 32'(rx_ready), 32'(1));
  endtask

  // Called at posedge+1; reset is asserted mid-cycle and checked at once.
  task automatic do_reset();
    #2 rstn = 1'b0;
    rx_valid = 1'b0;
    #1 check_reset_state();
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    m_err = 1'b0;
    m_run = 1'b0;
    m_inst_addr = 8'h00;
    m_data_addr = 8'h00;
    $display("reset pulse");
  endtask

  task automatic ctrl_byte(input logic [7:0] b);
    idle_gap();
    send_byte(b, 1'b0);
    if (!m_run) begin
      if (b == H_GO) begin
        if (!m_err) m_run = 1'b1;
      end else if (b != H_HALT) begin
        m_err = 1'b1;
      end
    end else if (b == H_HALT) begin
      m_run = 1'b0;
    end
    check_eq("ctrl_cpu_rstn", 32'(cpu_rstn), 32'(m_run));
    check_eq("ctrl_err", 32'(err), 32'(m_err));
    check_eq("ctrl_busy", 32'(busy), 32'(0));
    $display("ctrl byte %02h -> cpu_rstn=%0b err=%0b", b, cpu_rstn, err);
  endtask

  // One load transaction; payload_q supplies bytes or is filled randomly.
  task automatic do_load(input bit is_data, input logic [7:0] a, input logic [7:0] n,
                         input bit hold, input logic [7:0] csum_mask);
    int         words;
    int         nb;
    wr_t        exp_q[$];
    logic [7:0] x;
    wr_t        e;
    words = (n == 8'h00) ? 256 : int'(n);
    x = 8'h00;
    got_q.delete();
    if (payload_q.size() == 0) begin
      for (int i = 0; i < words * 4; i++) payload_q.push_back(8'($urandom));
    end
    for (int w = 0; w < words; w++) begin
      e.is_data = is_data;
      e.addr    = 8'(int'(a) + w);
      e.word    = {payload_q[4*w+3], payload_q[4*w+2], payload_q[4*w+1], payload_q[4*w]};
      exp_q.push_back(e);
    end
    if (!hold) idle_gap();
    send_byte(is_data ? H_D : H_I, hold);
    m_run = 1'b0;
    check_eq("hdr_cpu_rstn", 32'(cpu_rstn), 32'(0));
    check_eq("hdr_busy", 32'(busy), 32'(1));
    if (!hold) idle_gap();
    send_byte(a, hold);
    if (!hold) idle_gap();
    send_byte(n, hold);
    nb = payload_q.size();
    for (int i = 0; i < nb; i++) begin
      if (!hold) idle_gap();
      x ^= payload_q[i];
      send_byte(payload_q[i], hold && (i != nb - 1));
    end
`ifdef LOADER_CHECKSUM_EN
    check_eq("busy_before_csum", 32'(busy), 32'(1));
    send_byte(x ^ csum_mask, 1'b0);
    if (csum_mask != 8'h00) m_err = 1'b1;
`else
    @(posedge clk); #1;
`endif
    check_eq("busy_after_load", 32'(busy), 32'(0));
    repeat (2) begin
      @(posedge clk); #1;
    end
    check_eq("n_writes", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check_eq("wr_target", 32'(got_q[i].is_data), 32'(exp_q[i].is_data));
      check_eq("wr_addr", 32'(got_q[i].addr), 32'(exp_q[i].addr));
      check_eq("wr_data", got_q[i].word, exp_q[i].word);
    end
    if (is_data) m_data_addr = 8'(int'(a) + words);
    else         m_inst_addr = 8'(int'(a) + words);
    check_eq("end_inst_addr", 32'(inst_addr), 32'(m_inst_addr));
    check_eq("end_data_addr", 32'(data_addr), 32'(m_data_addr));
    check_eq("end_cpu_rstn", 32'(cpu_rstn), 32'(0));
    check_eq("end_err", 32'(err), 32'(m_err));
    $display("load %s addr=%02h words=%0d hold=%0b csum_mask=%02h writes=%0d err=%0b",
             is_data ? "D" : "I", a, words, hold, csum_mask, got_q.size(), err);
    payload_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    repeat (3) @(posedge clk);
    #1 check_reset_state();
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    payload_q = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    do_load(1'b0, 8'h10, 8'h02, 1'b0, 8'h00);
    do_load(1'b1, 8'hFF, 8'h02, 1'b0, 8'h00);

    ctrl_byte(8'h55);
    ctrl_byte(H_GO);
    do_reset();
    ctrl_byte(H_GO);

    do_load(1'b0, 8'h00, 8'h01, 1'b0, 8'h00);
    ctrl_byte(H_GO);
    ctrl_byte(8'h5A);
    ctrl_byte(H_HALT);

    do_load(1'b1, 8'h40, 8'h01, 1'b1, 8'h00);

    got_q.delete();
    send_byte(H_I, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    do_reset();
    repeat (8) begin
      @(posedge clk); #1;
    end
    check_eq("midload_no_strobe", 32'(got_q.size()), 32'(0));

    do_load(1'($urandom), 8'($urandom), 8'h00, 1'b1, 8'h00);

`ifdef LOADER_CHECKSUM_EN
    payload_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    do_load(1'b1, 8'h00, 8'h01, 1'b0, 8'h00);
    payload_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    do_load(1'b1, 8'h00, 8'h01, 1'b0, 8'h01);
    ctrl_byte(H_GO);
    do_reset();
`endif

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5:
          do_load(1'($urandom), 8'($urandom), 8'($urandom_range(1, 4)), 1'($urandom),
                  ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
        6, 7: ctrl_byte(H_GO);
        8: begin
          b = 8'($urandom);
          while (b == H_I || b == H_D) b = 8'($urandom);
          ctrl_byte(($urandom_range(0, 1) == 0) ? H_HALT : b);
        end
        default: do_reset();
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
